// File: rtl/fsm_esteira_multiestacao_pkg.sv
// ============================================================================
// Module   : fsm_esteira_multiestacao_pkg
// Brief    : Shared state encodings and fault codes for the conveyor controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package fsm_esteira_multiestacao_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOVING = 3'd1,
    ST_PAUSED = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } estado_t;

  localparam logic [1:0] FALHA_NENHUMA   = 2'd0;
  localparam logic [1:0] FALHA_INDICE    = 2'd1;
  localparam logic [1:0] FALHA_TIMEOUT   = 2'd2;
  localparam logic [1:0] FALHA_RESERVADA = 2'd3;

endpackage

`default_nettype wire

// File: rtl/fsm_esteira_multiestacao_if.sv
// ============================================================================
// Module   : fsm_esteira_multiestacao_if
// Brief    : Command/status/sensor bundle between fsm_mestre and the conveyor
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fsm_esteira_multiestacao_if #(
  parameter int NUM_ESTACOES = 3,
  parameter int IDX_W        = 2
);
  logic                    cmd_mover;
  logic [IDX_W-1:0]        cmd_destino;
  logic                    cmd_abortar;
  logic                    cmd_limpar;
  logic [NUM_ESTACOES-1:0] sensores;
  logic                    alarme_rolha;
  logic                    motor_ativo;
  logic                    ocupado;
  logic                    tarefa_concluida;
  logic                    falha;
  logic [1:0]              codigo_falha;
  logic [IDX_W-1:0]        estacao_atual;

  modport master (
    output cmd_mover, cmd_destino, cmd_abortar, cmd_limpar, sensores, alarme_rolha,
    input  motor_ativo, ocupado, tarefa_concluida, falha, codigo_falha, estacao_atual
  );

  modport slave (
    input  cmd_mover, cmd_destino, cmd_abortar, cmd_limpar, sensores, alarme_rolha,
    output motor_ativo, ocupado, tarefa_concluida, falha, codigo_falha, estacao_atual
  );
endinterface

`default_nettype wire

// File: rtl/fsm_esteira_multiestacao_filtro_sensor_alvo.sv
// ============================================================================
// Module   : filtro_sensor_alvo
// Brief    : Selects the target station sensor and debounces it with a
//            saturating consecutive-high counter
// Revision : 1.0
// ============================================================================
`default_nettype none

module filtro_sensor_alvo
  import fsm_esteira_multiestacao_pkg::*;
#(
  parameter int NUM_ESTACOES  = 3,
  parameter int IDX_W         = 2,
  parameter int FILTRO_CICLOS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    limpar,
  input  logic [NUM_ESTACOES-1:0] sensor,
  input  logic [IDX_W-1:0]        dest,
  output logic                    aceito
);

  localparam int FW = $clog2(FILTRO_CICLOS + 1);
  localparam logic [FW-1:0] c_alvo = FW'(FILTRO_CICLOS);

  logic [FW-1:0] cnt_q, cnt_d;
  logic          w_bit;

  always_comb begin
    // Out-of-range indices never reach MOVING, but keep the mux well defined.
    w_bit = (int'(dest) < NUM_ESTACOES) ? sensor[dest] : 1'b0;
    if (limpar || !w_bit) begin
      cnt_d = '0;
    end else if (cnt_q == c_alvo) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign aceito = (cnt_q == c_alvo);

endmodule

`default_nettype wire

// File: rtl/fsm_esteira_multiestacao.sv
// ============================================================================
// Module   : fsm_esteira_multiestacao
// Brief    : Multi-station conveyor controller with arrival filter, watchdog,
//            cork-alarm pause, abort and latched fault code
// Revision : 1.0
// ============================================================================
`default_nettype none

module fsm_esteira_multiestacao
  import fsm_esteira_multiestacao_pkg::*;
#(
  parameter int NUM_ESTACOES   = 3,
  parameter int IDX_W          = 2,
  parameter int FILTRO_CICLOS  = 4,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  fsm_esteira_multiestacao_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [TW-1:0] c_wd_max    = TW'(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] c_wd_ultimo = TW'(TIMEOUT_CICLOS - 1);

  estado_t          estado_q, estado_d;
  logic [IDX_W-1:0] dest_q, dest_d;
  logic [TW-1:0]    wd_q, wd_d;
  logic             motor_q, motor_d;
  logic             ocupado_q, ocupado_d;
  logic             concl_q, concl_d;
  logic             falha_q, falha_d;
  logic [1:0]       codigo_q, codigo_d;
  logic [IDX_W-1:0] estacao_q, estacao_d;
  logic             w_aceito, w_limpar_filtro, w_timeout;

  filtro_sensor_alvo #(
    .NUM_ESTACOES  (NUM_ESTACOES),
    .IDX_W         (IDX_W),
    .FILTRO_CICLOS (FILTRO_CICLOS)
  ) u_filtro (
    .clk    (clk),
    .reset  (reset),
    .limpar (w_limpar_filtro),
    .sensor (bus.sensores),
    .dest   (dest_q),
    .aceito (w_aceito)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= ST_IDLE;
      dest_q    <= '0;
      wd_q      <= '0;
      motor_q   <= 1'b0;
      ocupado_q <= 1'b0;
      concl_q   <= 1'b0;
      falha_q   <= 1'b0;
      codigo_q  <= FALHA_NENHUMA;
      estacao_q <= '0;
    end else begin
      estado_q  <= estado_d;
      dest_q    <= dest_d;
      wd_q      <= wd_d;
      motor_q   <= motor_d;
      ocupado_q <= ocupado_d;
      concl_q   <= concl_d;
      falha_q   <= falha_d;
      codigo_q  <= codigo_d;
      estacao_q <= estacao_d;
    end
  end

  // Watchdog fires on the last permitted MOVING cycle, so MOVING lasts exactly TIMEOUT_CICLOS.
  always_comb begin
    estado_d  = estado_q;
    dest_d    = dest_q;
    w_timeout = (wd_q == c_wd_ultimo);
    case (estado_q)
      ST_IDLE: begin
        if (bus.cmd_mover) begin
          dest_d   = bus.cmd_destino;
          estado_d = (int'(bus.cmd_destino) >= NUM_ESTACOES) ? ST_FAULT : ST_MOVING;
        end
      end
      ST_MOVING: begin
        if (bus.cmd_abortar)       estado_d = ST_IDLE;
        else if (w_aceito)         estado_d = ST_DONE;
        else if (w_timeout)        estado_d = ST_FAULT;
        else if (bus.alarme_rolha) estado_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (bus.cmd_abortar)        estado_d = ST_IDLE;
        else if (!bus.alarme_rolha) estado_d = ST_MOVING;
      end
      ST_DONE:  estado_d = ST_IDLE;
      ST_FAULT: if (bus.cmd_limpar) estado_d = ST_IDLE;
      default:  estado_d = ST_IDLE;
    endcase

    case (estado_q)
      ST_MOVING: wd_d = (wd_q == c_wd_max) ? wd_q : wd_q + TW'(1);
      ST_PAUSED: wd_d = wd_q;
      default:   wd_d = '0;
    endcase

    // Count only cycles spent in MOVING that stay in MOVING; the command cycle is excluded.
    w_limpar_filtro = (estado_q != ST_MOVING) || (estado_d != ST_MOVING);
  end

  always_comb begin
    motor_d   = (estado_d == ST_MOVING);
    ocupado_d = (estado_d == ST_MOVING) || (estado_d == ST_PAUSED);
    concl_d   = (estado_d == ST_DONE);
    falha_d   = (estado_d == ST_FAULT);
    estacao_d = (estado_d == ST_DONE) ? dest_q : estacao_q;
    codigo_d  = codigo_q;
    if ((estado_q != ST_FAULT) && (estado_d == ST_FAULT)) begin
      codigo_d = (estado_q == ST_IDLE) ? FALHA_INDICE : FALHA_TIMEOUT;
    end else if ((estado_q == ST_FAULT) && (estado_d == ST_IDLE)) begin
      codigo_d = FALHA_NENHUMA;
    end
  end

  assign bus.motor_ativo      = motor_q;
  assign bus.ocupado          = ocupado_q;
  assign bus.tarefa_concluida = concl_q;
  assign bus.falha            = falha_q;
  assign bus.codigo_falha     = codigo_q;
  assign bus.estacao_atual    = estacao_q;

endmodule

`default_nettype wire

// File: tb/tb_fsm_esteira_multiestacao.sv
// ============================================================================
// Module   : tb_fsm_esteira_multiestacao
// Brief    : Directed scoreboard bench for the multi-station conveyor controller
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fsm_esteira_multiestacao;

  localparam int EV_DONE  = 1;
  localparam int EV_FAULT = 2;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  ev_t  sb[$];
  logic falha_prev = 1'b0;

  fsm_esteira_multiestacao_if #(.NUM_ESTACOES(3), .IDX_W(2)) bus();

  fsm_esteira_multiestacao #(
    .NUM_ESTACOES   (3),
    .IDX_W          (2),
    .FILTRO_CICLOS  (4),
    .TIMEOUT_CICLOS (1000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int c, input int v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic issue(input int dest);
    bus.cmd_destino = 2'(dest);
    bus.cmd_mover   = 1'b1;
    tick(1);
    bus.cmd_mover   = 1'b0;
  endtask

  task automatic limpar();
    bus.cmd_limpar = 1'b1;
    tick(1);
    bus.cmd_limpar = 1'b0;
  endtask

  // Monitor: every done pulse or fault entry must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (reset && (bus.tarefa_concluida || (bus.falha && !falha_prev))) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_event: concl=%b falha=%b at cyc %0d, expected none",
                 bus.tarefa_concluida, bus.falha, cyc);
      end else begin
        e = sb.pop_front();
        chk("ev_kind", bus.tarefa_concluida ? EV_DONE : EV_FAULT, e.kind);
        chk("ev_cycle", cyc, e.cyc);
        if (e.kind == EV_DONE) chk("ev_estacao", int'(bus.estacao_atual), e.val);
        else                   chk("ev_codigo", int'(bus.codigo_falha), e.val);
      end
    end
    falha_prev = bus.falha;
  end

  initial begin
    int t0;
    bus.cmd_mover    = 1'b0;
    bus.cmd_destino  = '0;
    bus.cmd_abortar  = 1'b0;
    bus.cmd_limpar   = 1'b0;
    bus.sensores     = '0;
    bus.alarme_rolha = 1'b0;
    reset            = 1'b0;
    tick(2);
    chk("rst_motor", int'(bus.motor_ativo), 0);
    chk("rst_ocupado", int'(bus.ocupado), 0);
    chk("rst_concl", int'(bus.tarefa_concluida), 0);
    chk("rst_falha", int'(bus.falha), 0);
    chk("rst_codigo", int'(bus.codigo_falha), 0);
    chk("rst_estacao", int'(bus.estacao_atual), 0);
    reset = 1'b1;
    tick(2);

    // Move to station 1; sensor rises 10 cycles after the command.
    t0 = cyc;
    push(EV_DONE, t0 + 15, 1);
    issue(1);
    tick(3);
    chk("t1_motor_early", int'(bus.motor_ativo), 1);
    chk("t1_ocupado", int'(bus.ocupado), 1);
    issue(2);
    tick(5);
    bus.sensores[1] = 1'b1;
    chk("t1_motor_mid", int'(bus.motor_ativo), 1);
    tick(4);
    chk("t1_motor_late", int'(bus.motor_ativo), 1);
    chk("t1_no_early_done", int'(bus.tarefa_concluida), 0);
    tick(1);
    chk("t1_motor_off", int'(bus.motor_ativo), 0);
    chk("t1_ocupado_off", int'(bus.ocupado), 0);
    tick(1);
    chk("t1_pulse_one_cycle", int'(bus.tarefa_concluida), 0);
    chk("t1_estacao", int'(bus.estacao_atual), 1);
    bus.sensores = '0;
    tick(1);

    // Station 2 with a 3-cycle glitch before the real arrival.
    t0 = cyc;
    push(EV_DONE, t0 + 15, 2);
    issue(2);
    tick(2);
    bus.sensores[2] = 1'b1;
    tick(3);
    bus.sensores[2] = 1'b0;
    tick(4);
    bus.sensores[2] = 1'b1;
    chk("t2_motor_after_glitch", int'(bus.motor_ativo), 1);
    tick(5);
    chk("t2_motor_off", int'(bus.motor_ativo), 0);
    tick(1);
    bus.sensores = '0;
    chk("t2_estacao", int'(bus.estacao_atual), 2);

    // Station 0, 50-cycle cork alarm pause, then timeout after 1000 MOVING cycles.
    t0 = cyc;
    push(EV_FAULT, t0 + 1051, 2);
    issue(0);
    tick(99);
    bus.alarme_rolha = 1'b1;
    tick(1);
    chk("t3_pause_motor", int'(bus.motor_ativo), 0);
    chk("t3_pause_ocupado", int'(bus.ocupado), 1);
    tick(24);
    chk("t3_pause_motor_mid", int'(bus.motor_ativo), 0);
    chk("t3_pause_ocupado_mid", int'(bus.ocupado), 1);
    tick(25);
    bus.alarme_rolha = 1'b0;
    tick(1);
    chk("t3_resume_motor", int'(bus.motor_ativo), 1);
    tick(899);
    chk("t3_no_fault_yet", int'(bus.falha), 0);
    chk("t3_motor_before_to", int'(bus.motor_ativo), 1);
    tick(1);
    chk("t3_falha", int'(bus.falha), 1);
    chk("t3_codigo", int'(bus.codigo_falha), 2);
    chk("t3_motor_fault", int'(bus.motor_ativo), 0);
    limpar();
    chk("t3_clear_falha", int'(bus.falha), 0);
    chk("t3_clear_codigo", int'(bus.codigo_falha), 0);

    // Station 0, no sensor: plain timeout, cmd_mover ignored in FAULT.
    t0 = cyc;
    push(EV_FAULT, t0 + 1001, 2);
    issue(0);
    tick(999);
    chk("t4_motor_999", int'(bus.motor_ativo), 1);
    chk("t4_no_fault_yet", int'(bus.falha), 0);
    tick(1);
    chk("t4_falha", int'(bus.falha), 1);
    chk("t4_codigo", int'(bus.codigo_falha), 2);
    issue(1);
    chk("t4_ignored_falha", int'(bus.falha), 1);
    chk("t4_ignored_motor", int'(bus.motor_ativo), 0);
    chk("t4_ignored_ocupado", int'(bus.ocupado), 0);
    tick(1);
    chk("t4_ignored_motor2", int'(bus.motor_ativo), 0);
    limpar();
    chk("t4_clear_falha", int'(bus.falha), 0);
    chk("t4_clear_codigo", int'(bus.codigo_falha), 0);
    chk("t4_clear_ocupado", int'(bus.ocupado), 0);

    // Invalid index 3.
    t0 = cyc;
    push(EV_FAULT, t0 + 1, 1);
    issue(3);
    chk("t5_motor", int'(bus.motor_ativo), 0);
    chk("t5_falha", int'(bus.falha), 1);
    chk("t5_codigo", int'(bus.codigo_falha), 1);
    tick(1);
    chk("t5_motor2", int'(bus.motor_ativo), 0);
    limpar();
    chk("t5_clear_codigo", int'(bus.codigo_falha), 0);

    // Abort mid-move; later sensor activity must not produce a done pulse.
    issue(2);
    tick(4);
    chk("t6_motor_before_abort", int'(bus.motor_ativo), 1);
    bus.cmd_abortar = 1'b1;
    tick(1);
    bus.cmd_abortar = 1'b0;
    chk("t6_abort_motor", int'(bus.motor_ativo), 0);
    chk("t6_abort_ocupado", int'(bus.ocupado), 0);
    chk("t6_abort_estacao", int'(bus.estacao_atual), 2);
    bus.sensores[2] = 1'b1;
    tick(8);
    bus.sensores = '0;

    // Asynchronous reset mid-move.
    issue(1);
    tick(4);
    chk("t6_motor_before_rst", int'(bus.motor_ativo), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_motor", int'(bus.motor_ativo), 0);
    chk("t6_rst_ocupado", int'(bus.ocupado), 0);
    chk("t6_rst_estacao", int'(bus.estacao_atual), 0);
    tick(2);
    reset = 1'b1;
    tick(2);
    chk("t6_post_rst_motor", int'(bus.motor_ativo), 0);
    chk("t6_post_rst_ocupado", int'(bus.ocupado), 0);

    tick(3);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fsm_esteira_multiestacao.md
Name: fsm_esteira_multiestacao

Overview:
Single parametrised conveyor controller replacing the per-destination fsm_esteira instances in the bottling line. The master FSM issues one move command with a destination station index, and the block drives the belt motor until that station's sensor is stably asserted. Adds sensor glitch filtering, a movement watchdog, pause on the cork alarm, abort, and latched fault reporting. Sits between fsm_mestre and the station sensors (SW inputs).

Parameters:
NUM_ESTACOES, 3, number of station sensors/destinations (2..16)
IDX_W, 2, width of station index; must satisfy 2**IDX_W >= NUM_ESTACOES
FILTRO_CICLOS, 4, consecutive high cycles on target sensor required to accept arrival (>=1)
TIMEOUT_CICLOS, 1000, max MOVING cycles before watchdog fault (>=FILTRO_CICLOS+1)

Ports:
clk  input  1  system clock (CLOCK_50 domain)
reset  input  1  asynchronous, active-low reset
cmd_mover  input  1  one-cycle start request; sampled only in IDLE
cmd_destino  input  IDX_W  target station index, sampled with cmd_mover
cmd_abortar  input  1  stop current move, return to IDLE, no done pulse
cmd_limpar  input  1  clears FAULT state
sensores  input  NUM_ESTACOES  station presence sensors, already synchronous, active-high
alarme_rolha  input  1  cork-empty alarm; freezes belt while high
motor_ativo  output  1  belt motor enable
ocupado  output  1  high in MOVING and PAUSED
tarefa_concluida  output  1  one-cycle pulse on accepted arrival
falha  output  1  high while in FAULT
codigo_falha  output  2  0 none, 1 invalid index, 2 timeout, 3 reserved
estacao_atual  output  IDX_W  index of last station reached

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; destination register, filter counter and watchdog counter cleared.
- States: IDLE, MOVING, PAUSED, DONE, FAULT. All outputs are registered.
- IDLE: on cmd_mover=1, latch cmd_destino. If the index >= NUM_ESTACOES, go to FAULT with codigo_falha=1. Otherwise go to MOVING; motor_ativo rises the next cycle.
- MOVING: motor_ativo=1.
  - Filter counter increments while sensores[dest]=1 and resets to 0 on any low cycle.
  - When the counter reaches FILTRO_CICLOS, go to DONE.
  - Watchdog counter increments each MOVING cycle. When it reaches TIMEOUT_CICLOS without arrival, go to FAULT with codigo_falha=2.
- PAUSED: entered from MOVING when alarme_rolha=1. motor_ativo=0. Watchdog is frozen; filter counter is cleared. Returns to MOVING the cycle after alarme_rolha falls.
- DONE: lasts one cycle. tarefa_concluida=1, estacao_atual<=dest, motor_ativo=0. Then go to IDLE.
- FAULT: motor_ativo=0, falha=1. Stays until cmd_limpar=1, which goes to IDLE and sets codigo_falha=0. cmd_mover is ignored in FAULT.
- cmd_abortar in MOVING or PAUSED goes to IDLE next cycle with motor off and no done pulse; estacao_atual is unchanged. It is ignored in other states.
- Priority within a cycle (MOVING): abortar > arrival > timeout > alarme pause.
  - Arrival and timeout in the same cycle: arrival wins.
  - Arrival and alarm rising in the same cycle: arrival wins.
- Target sensor already high at command: filtering still applies, so minimum latency from cmd_mover to tarefa_concluida is FILTRO_CICLOS+1 cycles (FILTRO_CICLOS+2 for the cycle the pulse is visible). The motor runs during those cycles.
- cmd_mover while ocupado=1 is ignored (no queueing).
- Non-target sensors are ignored.
- Counters saturate and never wrap.
- Counter widths are $clog2(TIMEOUT_CICLOS+1) and $clog2(FILTRO_CICLOS+1).

Decomposition:
- Shared package/include (esteira_defs): state encodings, codigo_falha constants (FALHA_NENHUMA=0, FALHA_INDICE=1, FALHA_TIMEOUT=2).
- One natural sub-module: filtro_sensor_alvo, holding the mux of sensores by dest index plus the saturating consecutive-high counter. Ports: clk, reset, limpar, sensor, aceito.
- The watchdog counter stays inline.

Test Plan:
1. Defaults, dest=1; raise sensores[1] 10 cycles after cmd_mover and hold it -> motor high throughout; tarefa_concluida pulses once 4 cycles after the rise; estacao_atual=1; ocupado falls.
2. dest=2; sensores[2] glitches high for 3 cycles, drops, then holds high -> no done pulse after the glitch; done pulse fires 4 cycles after the final rise.
3. dest=0; alarme_rolha high for 50 cycles mid-move -> motor_ativo=0 and ocupado=1 during the pause; watchdog total MOVING cycles still 1000 (timeout at 1000 moving cycles, not 950).
4. dest=0, sensors never asserted -> falha=1, codigo_falha=2 after 1000 moving cycles; cmd_mover ignored; cmd_limpar returns to IDLE with codigo_falha=0.
5. cmd_destino=3 with NUM_ESTACOES=3 -> FAULT with codigo_falha=1; motor never asserted.
6. Mid-move cmd_abortar, and separately async reset asserted mid-move -> motor drops (immediately for reset, next cycle for abort); no done pulse; estacao_atual unchanged (reset: 0).
